snes_clock_gen: RTL and testbench

Parametrised clock and strobe generator for the SNES controller interface. It replaces the fixed divide-by-constant clock with a runtime-programmable half period, a configurable idle level and two modes. Continuous mode produces a free-running divided clock. Burst mode emits exactly N clock pulses and then stops, which is what the controller shift sequence needs (e.g. 16 pulses after latch). It also provides edge strobes so downstream logic samples data in the clk_i domain without treating clk_o as a clock.

---
 rtl/snes_pkg.sv | 13 +
 rtl/snes_half_counter.sv | 34 +++
 rtl/snes_clock_gen.sv | 179 +++++++++++++++++
 tb/tb_snes_clock_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
// Shared types and default constants for the SNES clock/strobe generator.
package snes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONT  = 2'd1,
        BURST = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_HALF = 25;
    localparam logic        IDLE_LVL     = 1'b1;

endpackage

// File: rtl/snes_half_counter.sv
// Half-period counter: counts up while enabled and flags terminal count when it reaches half_i.
module snes_half_counter #(
    parameter int unsigned CNT_W = 14
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tc_c  = en_i && (cnt_q == half_i);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snes_clock_gen.sv
// Programmable SNES controller clock with continuous and N-pulse burst modes,
// edge strobes in the clk_i domain, and glitch-free half-period reloads.
module snes_clock_gen #(
    parameter int unsigned CNT_W        = 14,
    parameter int unsigned DEFAULT_HALF = snes_pkg::DEFAULT_HALF,
    parameter int unsigned BURST_W      = 5,
    parameter logic        IDLE_LVL     = snes_pkg::IDLE_LVL
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               en_i,
    input  logic               mode_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   half_period_i,
    input  logic               load_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               clk_o,
    output logic               rise_o,
    output logic               fall_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [BURST_W-1:0] pulse_cnt_o
);

    import snes_pkg::*;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic               pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]   pend_val_q, pend_val_d;
    logic [BURST_W-1:0] n_q, n_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;
    logic               clk_q, clk_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cnt_clr_c;
    logic               cnt_en_c;
    logic               tc_c;
    logic               toggle_c;
    logic               ret_c;
    logic               apply_c;
    logic [BURST_W-1:0] pcnt_inc_c;

    snes_half_counter #(
        .CNT_W (CNT_W)
    ) u_half_counter (
        .clk_i  (clk_i),
        .reset  (reset),
        .clr_i  (cnt_clr_c),
        .en_i   (cnt_en_c),
        .half_i (h_q),
        .tc_c   (tc_c)
    );

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        n_d        = n_q;
        pcnt_d     = pcnt_q;
        clk_d      = clk_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        done_d     = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_en_c   = 1'b0;
        toggle_c   = 1'b0;
        pcnt_inc_c = pcnt_q + BURST_W'(1);

        // A return edge is a toggle that brings clk_o back to its idle level.
        ret_c = tc_c && (clk_q != IDLE_LVL);

        unique case (state_q)
            IDLE: begin
                cnt_clr_c = 1'b1;
                clk_d     = IDLE_LVL;
                if (start_i && mode_i) begin
                    state_d = BURST;
                    n_d     = burst_len_i;
                    pcnt_d  = '0;
                end else if (en_i && !mode_i) begin
                    state_d = CONT;
                end
            end
            CONT: begin
                cnt_en_c = 1'b1;
                toggle_c = tc_c;
                if (ret_c && !en_i) begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (n_q == '0) begin
                    cnt_clr_c = 1'b1;
                    ret_c     = 1'b0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else begin
                    cnt_en_c = 1'b1;
                    toggle_c = tc_c;
                    if (ret_c) begin
                        pcnt_d = pcnt_inc_c;
                        if (pcnt_inc_c == n_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ret_c   = 1'b0;
            end
        endcase

        if (toggle_c) begin
            clk_d  = ~clk_q;
            rise_d = ~clk_q;
            fall_d = clk_q;
        end

        // Half-period changes only at pulse boundaries so no runt half-period is emitted.
        apply_c = (state_q == IDLE) || ret_c;
        if (load_i) begin
            if (apply_c) begin
                h_d        = half_period_i;
                pend_vld_d = 1'b0;
            end else begin
                pend_vld_d = 1'b1;
                pend_val_d = half_period_i;
            end
        end else if (apply_c && pend_vld_q) begin
            h_d        = pend_val_q;
            pend_vld_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q    <= IDLE;
            h_q        <= CNT_W'(DEFAULT_HALF);
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            n_q        <= '0;
            pcnt_q     <= '0;
            clk_q      <= IDLE_LVL;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            n_q        <= n_d;
            pcnt_q     <= pcnt_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign clk_o       = clk_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pulse_cnt_o = pcnt_q;

endmodule

// File: tb/tb_snes_clock_gen.sv
// Scoreboard bench for snes_clock_gen: stimulus queues expected strobe events,
// a negedge monitor pops and checks them whenever a strobe appears.
module tb_snes_clock_gen;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        en_i = 1'b0;
    logic        mode_i = 1'b0;
    logic        start_i = 1'b0;
    logic [13:0] half_period_i = '0;
    logic        load_i = 1'b0;
    logic [4:0]  burst_len_i = '0;
    logic        clk_o, rise_o, fall_o, busy_o, done_o;
    logic [4:0]  pulse_cnt_o;

    typedef struct {
        int         edge_n;
        logic       r;
        logic       f;
        logic       d;
        logic [4:0] pc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    snes_clock_gen dut (
        .clk_i         (clk_i),
        .reset         (reset),
        .en_i          (en_i),
        .mode_i        (mode_i),
        .start_i       (start_i),
        .half_period_i (half_period_i),
        .load_i        (load_i),
        .burst_len_i   (burst_len_i),
        .clk_o         (clk_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pulse_cnt_o   (pulse_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Edge numbering: after the k-th posedge, cyc == k.
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic push(input int e, input logic r, input logic f, input logic d, input logic [4:0] pc);
        ev_t ev;
        ev.edge_n = e;
        ev.r      = r;
        ev.f      = f;
        ev.d      = d;
        ev.pc     = pc;
        exp_q.push_back(ev);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk_i);
    endtask

    task automatic load_h(input logic [13:0] h);
        load_i        = 1'b1;
        half_period_i = h;
        @(negedge clk_i);
        load_i        = 1'b0;
    endtask

    // Monitor: any strobe must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (rise_o || fall_o || done_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: cycle %0d r=%0b f=%0b d=%0b pc=%0d, none expected",
                         cyc, rise_o, fall_o, done_o, pulse_cnt_o);
            end else begin
                ev_t ev;
                logic exp_clk;
                ev = exp_q.pop_front();
                exp_clk = ev.r ? 1'b1 : (ev.f ? 1'b0 : 1'b1);
                if (ev.edge_n != cyc || ev.r != rise_o || ev.f != fall_o || ev.d != done_o
                    || ev.pc != pulse_cnt_o || exp_clk != clk_o) begin
                    bad++;
                    $display("FAIL strobe_event: got cyc=%0d r=%0b f=%0b d=%0b pc=%0d clk=%0b want cyc=%0d r=%0b f=%0b d=%0b pc=%0d clk=%0b",
                             cyc, rise_o, fall_o, done_o, pulse_cnt_o, clk_o,
                             ev.edge_n, ev.r, ev.f, ev.d, ev.pc, exp_clk);
                end
            end
        end
    end

    initial begin
        int e0;

        // Reset defaults
        repeat (2) @(negedge clk_i);
        check("rst_clk", int'(clk_o), 1);
        check("rst_busy", int'(busy_o), 0);
        check("rst_pcnt", int'(pulse_cnt_o), 0);
        check("rst_strobes", int'({rise_o, fall_o, done_o}), 0);
        reset = 1'b0;
        @(negedge clk_i);

        // Continuous with default H=25: edges every 26 cycles
        en_i = 1'b1;
        e0 = cyc + 1;
        push(e0 + 26, 1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 52, 1'b1, 1'b0, 1'b0, 5'd0);
        push(e0 + 78, 1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 104, 1'b1, 1'b0, 1'b0, 5'd0);
        @(negedge clk_i);
        check("cont_busy", int'(busy_o), 1);
        wait_until(e0 + 80);
        en_i = 1'b0;
        wait_until(e0 + 107);
        check("cont_idle_busy", int'(busy_o), 0);
        check("cont_idle_clk", int'(clk_o), 1);

        // Burst H=2, N=3
        load_h(14'd2);
        mode_i      = 1'b1;
        start_i     = 1'b1;
        burst_len_i = 5'd3;
        e0 = cyc + 1;
        push(e0 + 3,  1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 6,  1'b1, 1'b0, 1'b0, 5'd1);
        push(e0 + 9,  1'b0, 1'b1, 1'b0, 5'd1);
        push(e0 + 12, 1'b1, 1'b0, 1'b0, 5'd2);
        push(e0 + 15, 1'b0, 1'b1, 1'b0, 5'd2);
        push(e0 + 18, 1'b1, 1'b0, 1'b1, 5'd3);
        @(negedge clk_i);
        start_i = 1'b0;
        check("burst_busy", int'(busy_o), 1);
        wait_until(e0 + 17);
        check("burst_busy_late", int'(busy_o), 1);
        wait_until(e0 + 19);
        check("burst_end_busy", int'(busy_o), 0);
        check("burst_end_pcnt", int'(pulse_cnt_o), 3);

        // Zero-length burst
        start_i     = 1'b1;
        burst_len_i = 5'd0;
        e0 = cyc + 1;
        push(e0 + 1, 1'b0, 1'b0, 1'b1, 5'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_until(e0 + 6);
        check("zero_clk", int'(clk_o), 1);
        check("zero_busy", int'(busy_o), 0);

        // Mid-run load: CONT at H=4, reload to H=1 while clk_o low
        load_h(14'd4);
        mode_i = 1'b0;
        en_i   = 1'b1;
        e0 = cyc + 1;
        push(e0 + 5,  1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 10, 1'b1, 1'b0, 1'b0, 5'd0);
        push(e0 + 12, 1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 14, 1'b1, 1'b0, 1'b0, 5'd0);
        push(e0 + 16, 1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 18, 1'b1, 1'b0, 1'b0, 5'd0);
        wait_until(e0 + 6);
        load_h(14'd1);
        wait_until(e0 + 16);
        en_i = 1'b0;
        wait_until(e0 + 22);
        check("midload_busy", int'(busy_o), 0);

        // en_i drop one cycle after a fall with H=3
        load_h(14'd3);
        en_i = 1'b1;
        e0 = cyc + 1;
        push(e0 + 4, 1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 8, 1'b1, 1'b0, 1'b0, 5'd0);
        wait_until(e0 + 4);
        en_i = 1'b0;
        wait_until(e0 + 9);
        check("endrop_busy", int'(busy_o), 0);
        wait_until(e0 + 30);
        check("endrop_clk", int'(clk_o), 1);

        // Burst with H=0 (divide-by-2), N=2
        load_h(14'd0);
        mode_i      = 1'b1;
        start_i     = 1'b1;
        burst_len_i = 5'd2;
        e0 = cyc + 1;
        push(e0 + 1, 1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 2, 1'b1, 1'b0, 1'b0, 5'd1);
        push(e0 + 3, 1'b0, 1'b1, 1'b0, 5'd1);
        push(e0 + 4, 1'b1, 1'b0, 1'b1, 5'd2);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_until(e0 + 6);
        check("h0_pcnt", int'(pulse_cnt_o), 2);

        // Reset during pulse 2 of an N=5 burst
        load_h(14'd2);
        start_i     = 1'b1;
        burst_len_i = 5'd5;
        e0 = cyc + 1;
        push(e0 + 3, 1'b0, 1'b1, 1'b0, 5'd0);
        push(e0 + 6, 1'b1, 1'b0, 1'b0, 5'd1);
        push(e0 + 9, 1'b0, 1'b1, 1'b0, 5'd1);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_until(e0 + 9);
        check("prereset_clk", int'(clk_o), 0);
        reset = 1'b1;
        @(negedge clk_i);
        reset = 1'b0;
        check("abort_clk", int'(clk_o), 1);
        check("abort_busy", int'(busy_o), 0);
        check("abort_pcnt", int'(pulse_cnt_o), 0);
        check("abort_done", int'(done_o), 0);
        repeat (20) @(negedge clk_i);
        check("abort_still_idle", int'(busy_o), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
